// File: rtl/fp_pkg.sv
// fp_pkg: single-precision field constants, subtractor FSM states and the unpacked operand type
package fp_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS = 127;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0] mant;
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } unp_t;
endpackage

// File: rtl/fp_unpack.sv
// fp_unpack: splits a single-precision word into fields and classifies it, flushing denormals to zero
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0] x,
  output unp_t        u
);
  logic [EXP_W-1:0] e;
  logic [MAN_W-1:0] m;
  assign e = x[30:23];
  assign m = x[22:0];
  assign u.sign = x[31];
  assign u.exp = e;
  assign u.mant = {|e, m};
  assign u.is_zero = e == '0;
  assign u.is_inf = &e && m == '0;
  assign u.is_nan = &e && |m;
endmodule

// File: rtl/fp_subtractor_seq.sv
// fp_subtractor_seq: multi-cycle a - b with bit-serial alignment and normalisation
module fp_subtractor_seq
  import fp_pkg::*;
#(
  parameter int ALIGN_MAX = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);
  unp_t ua, ub;
  state_t state;
  logic sx, eff_sub, a_big, special;
  logic [EXP_W-1:0] ex, diff;
  logic [MAN_W:0] mx, my;
  logic [7:0] cnt;
  logic [MAN_W+1:0] sum;
  logic [31:0] bn, sres;
  fp_unpack u_a (.x(a), .u(ua));
  fp_unpack u_b (.x(b), .u(ub));
  assign bn = {~b[31], b[30:0]};
  assign a_big = {ua.exp, ua.mant} >= {ub.exp, ub.mant};
  assign diff = a_big ? ua.exp - ub.exp : ub.exp - ua.exp;
  assign special = ua.is_nan | ub.is_nan | ua.is_inf | ub.is_inf | ua.is_zero | ub.is_zero;
  // inf-inf with equal input signs is a true cancellation of infinities
  assign sres = (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && ua.sign == ub.sign)) ? QNAN :
                ua.is_inf ? a :
                ub.is_inf ? bn :
                (ua.is_zero && ub.is_zero) ? {ua.sign & ~ub.sign, 31'b0} :
                ua.is_zero ? bn : a;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          sx <= a_big ? ua.sign : ~ub.sign;
          ex <= a_big ? ua.exp : ub.exp;
          mx <= a_big ? ua.mant : ub.mant;
          my <= a_big ? ub.mant : ua.mant;
          cnt <= (diff > 8'(ALIGN_MAX)) ? 8'(ALIGN_MAX) : diff;
          eff_sub <= ua.sign == ub.sign;
          if (special) begin
            result <= sres;
            out_valid <= 1'b1;
            state <= DONE;
          end else state <= ALIGN;
        end
        ALIGN: if (cnt != '0) begin
          my <= my >> 1;
          cnt <= cnt - 8'd1;
        end else state <= ADD;
        ADD: begin
          sum <= eff_sub ? {1'b0, mx} - {1'b0, my} : {1'b0, mx} + {1'b0, my};
          state <= NORM;
        end
        NORM: if (sum[24]) begin
          sum <= sum >> 1;
          ex <= ex + 8'd1;
          if (ex == 8'd254) begin
            result <= {sx, 8'hFF, 23'h0};
            out_valid <= 1'b1;
            state <= DONE;
          end
        end else if (sum == '0) begin
          result <= '0;
          out_valid <= 1'b1;
          state <= DONE;
        end else if (!sum[23] && ex > 8'd1) begin
          sum <= sum << 1;
          ex <= ex - 8'd1;
        end else begin
          result <= sum[23] ? {sx, ex, sum[22:0]} : {sx, 31'b0};
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
